// File: rtl/pong_game_engine.sv
// pong_game_engine: ball, paddle, score and match state for the VGA pong renderer.
// All state advances once per frame_tick; outputs are registers read directly by the wrapper.
// A start pulse is taken in any cycle, with or without frame_tick.
// Optional build macro PONG_AI_P2_EN: the right paddle tracks the ball instead of KEY[1:0].
`timescale 1ns/1ps
module pong_game_engine #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int PADDLE_H     = 80,
  parameter int PADDLE_W     = 8,
  parameter int P1_X         = 20,
  parameter int BALL_SZ      = 8,
  parameter int BALL_STEP    = 4,
  parameter int PADDLE_STEP  = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [3:0]  KEY,
  output logic [10:0] XDotPosition,
  output logic [10:0] YDotPosition,
  output logic [10:0] P1y,
  output logic [10:0] P2y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  game_state,
  output logic        game_over
);
  localparam int P2_X    = H_ACTIVE - P1_X - PADDLE_W;
  localparam int X_CTR   = (H_ACTIVE - BALL_SZ) / 2;
  localparam int Y_CTR   = (V_ACTIVE - BALL_SZ) / 2;
  localparam int PAD_CTR = (V_ACTIVE - PADDLE_H) / 2;
  localparam int PAD_MAX = V_ACTIVE - PADDLE_H;
  localparam int Y_MAX   = V_ACTIVE - BALL_SZ;
  localparam int P1_FACE = P1_X + PADDLE_W;
  localparam int P2_FACE = P2_X - BALL_SZ;
  localparam int CNT_W   = $clog2(SERVE_FRAMES + 1);

  localparam logic signed [11:0] BALL_STEP_S = 12'(BALL_STEP);
  localparam logic signed [11:0] X_MAX_S     = 12'(H_ACTIVE - BALL_SZ);
  localparam logic signed [11:0] Y_MAX_S     = 12'(Y_MAX);
  localparam logic signed [11:0] P1_FACE_S   = 12'(P1_FACE);
  localparam logic signed [11:0] P2_FACE_S   = 12'(P2_FACE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [10:0]        x_q, x_d, y_q, y_d;
  logic [10:0]        p1y_q, p1y_d, p2y_q, p2y_d;
  logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [3:0]         score1_q, score1_d, score2_q, score2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               game_over_q;

  logic               p1_up, p1_dn, p2_up, p2_dn;
  logic signed [11:0] nx, ny;
  logic               p1_overlap, p2_overlap, p1_hit, p2_hit;

  // One frame of paddle travel: single direction moves and clamps, both/neither holds.
  function automatic logic [10:0] paddle_next(input logic [10:0] y, input logic up, input logic dn);
    paddle_next = y;
    if (up && !dn)
      paddle_next = (y < 11'(PADDLE_STEP)) ? 11'd0 : y - 11'(PADDLE_STEP);
    else if (dn && !up)
      paddle_next = (y > 11'(PAD_MAX - PADDLE_STEP)) ? 11'(PAD_MAX) : y + 11'(PADDLE_STEP);
  endfunction

  assign p1_up = ~KEY[3];
  assign p1_dn = ~KEY[2];

`ifdef PONG_AI_P2_EN
  logic [11:0] ball_cy, p2_cy;
  // Right paddle chases the ball centre, holding inside a one-step dead band.
  always_comb begin
    ball_cy = {1'b0, y_q} + 12'(BALL_SZ / 2);
    p2_cy   = {1'b0, p2y_q} + 12'(PADDLE_H / 2);
    p2_up   = (ball_cy + 12'(PADDLE_STEP)) < p2_cy;
    p2_dn   = ball_cy > (p2_cy + 12'(PADDLE_STEP));
  end
`else
  assign p2_up = ~KEY[1];
  assign p2_dn = ~KEY[0];
`endif

  // Candidate ball position and paddle contact tests, all from pre-tick positions.
  always_comb begin
    nx = $signed({1'b0, x_q}) + (dx_neg_q ? -BALL_STEP_S : BALL_STEP_S);
    ny = $signed({1'b0, y_q}) + (dy_neg_q ? -BALL_STEP_S : BALL_STEP_S);
    p1_overlap = (({1'b0, y_q} + 12'(BALL_SZ)) > {1'b0, p1y_q}) &&
                 ({1'b0, y_q} < ({1'b0, p1y_q} + 12'(PADDLE_H)));
    p2_overlap = (({1'b0, y_q} + 12'(BALL_SZ)) > {1'b0, p2y_q}) &&
                 ({1'b0, y_q} < ({1'b0, p2y_q} + 12'(PADDLE_H)));
    p1_hit = dx_neg_q && (x_q >= 11'(P1_FACE)) && (nx <= P1_FACE_S) && p1_overlap;
    p2_hit = !dx_neg_q && (x_q <= 11'(P2_FACE)) && (nx >= P2_FACE_S) && p2_overlap;
  end

  // Match FSM next state together with ball, paddle, score and serve counter updates.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    p1y_d    = p1y_q;
    p2y_d    = p2y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_SERVE;
          score1_d = 4'd0;
          score2_d = 4'd0;
          x_d      = 11'(X_CTR);
          y_d      = 11'(Y_CTR);
          cnt_d    = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
          p2y_d = paddle_next(p2y_q, p2_up, p2_dn);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(SERVE_FRAMES))
            state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
          p2y_d = paddle_next(p2y_q, p2_up, p2_dn);
          // Top/bottom walls
          if (ny <= 12'sd0) begin
            y_d      = 11'd0;
            dy_neg_d = 1'b0;
          end else if (ny >= Y_MAX_S) begin
            y_d      = 11'(Y_MAX);
            dy_neg_d = 1'b1;
          end else begin
            y_d = ny[10:0];
          end
          // Paddles first, then misses; a miss recentres the ball and overrides the wall result.
          if (p1_hit) begin
            x_d      = 11'(P1_FACE);
            dx_neg_d = 1'b0;
          end else if (p2_hit) begin
            x_d      = 11'(P2_FACE);
            dx_neg_d = 1'b1;
          end else if (nx <= 12'sd0) begin
            score2_d = score2_q + 4'd1;
            dx_neg_d = 1'b1;
            x_d      = 11'(X_CTR);
            y_d      = 11'(Y_CTR);
            cnt_d    = '0;
            state_d  = (score2_d == 4'(MAX_SCORE)) ? S_OVER : S_SERVE;
          end else if (nx >= X_MAX_S) begin
            score1_d = score1_q + 4'd1;
            dx_neg_d = 1'b0;
            x_d      = 11'(X_CTR);
            y_d      = 11'(Y_CTR);
            cnt_d    = '0;
            state_d  = (score1_d == 4'(MAX_SCORE)) ? S_OVER : S_SERVE;
          end else begin
            x_d = nx[10:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset puts the ball and paddles at centre with the ball heading down-right.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= 11'(X_CTR);
      y_q         <= 11'(Y_CTR);
      p1y_q       <= 11'(PAD_CTR);
      p2y_q       <= 11'(PAD_CTR);
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      cnt_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      p1y_q       <= p1y_d;
      p2y_q       <= p2y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      cnt_q       <= cnt_d;
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign XDotPosition = x_q;
  assign YDotPosition = y_q;
  assign P1y          = p1y_q;
  assign P2y          = p2y_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign game_state   = state_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed vector table plus randomized play against a rule-level model.
`timescale 1ns/1ps
module tb_pong_game_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic [3:0]  key;
  logic [10:0] x_o, y_o, p1_o, p2_o;
  logic [3:0]  s1_o, s2_o;
  logic [1:0]  gs_o;
  logic        go_o;

  pong_game_engine dut (
    .clock(clk), .reset(rst), .frame_tick(frame_tick), .start(start), .KEY(key),
    .XDotPosition(x_o), .YDotPosition(y_o), .P1y(p1_o), .P2y(p2_o),
    .score1(s1_o), .score2(s2_o), .game_state(gs_o), .game_over(go_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game rules as plain integer arithmetic.
  int m_x, m_y, m_p1, m_p2, m_dx, m_dy, m_s1, m_s2, m_st, m_cnt;

  task automatic model_reset();
    m_x = 396; m_y = 296; m_p1 = 260; m_p2 = 260;
    m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
  endtask

  function automatic int move_pad(int y, bit up, bit dn);
    if (up && !dn) return (y - 6 < 0) ? 0 : y - 6;
    if (dn && !up) return (y + 6 > 520) ? 520 : y + 6;
    return y;
  endfunction

  task automatic model_cycle(bit tick, bit st, logic [3:0] k);
    int ox, oy, op1, op2, nx, ny;
    bit ov1, ov2, up2, dn2;
    if ((m_st == 0 || m_st == 3) && st) begin
      m_st = 1; m_s1 = 0; m_s2 = 0; m_x = 396; m_y = 296; m_cnt = 0;
      return;
    end
    if (!tick || m_st == 0 || m_st == 3) return;
    ox = m_x; oy = m_y; op1 = m_p1; op2 = m_p2;
`ifdef PONG_AI_P2_EN
    up2 = (oy + 4) < (op2 + 40 - 6);
    dn2 = (oy + 4) > (op2 + 40 + 6);
`else
    up2 = !k[1];
    dn2 = !k[0];
`endif
    m_p1 = move_pad(op1, !k[3], !k[2]);
    m_p2 = move_pad(op2, up2, dn2);
    if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == 60) m_st = 2;
      return;
    end
    ny = oy + 4 * m_dy;
    if (ny <= 0) begin m_y = 0; m_dy = 1; end
    else if (ny >= 592) begin m_y = 592; m_dy = -1; end
    else m_y = ny;
    nx  = ox + 4 * m_dx;
    ov1 = (oy + 8 > op1) && (oy < op1 + 80);
    ov2 = (oy + 8 > op2) && (oy < op2 + 80);
    if (m_dx < 0 && ox >= 28 && nx <= 28 && ov1) begin m_x = 28; m_dx = 1; end
    else if (m_dx > 0 && ox <= 764 && nx >= 764 && ov2) begin m_x = 764; m_dx = -1; end
    else if (nx <= 0) begin
      m_s2++; m_dx = -1; m_x = 396; m_y = 296; m_cnt = 0;
      m_st = (m_s2 == 9) ? 3 : 1;
    end else if (nx >= 792) begin
      m_s1++; m_dx = 1; m_x = 396; m_y = 296; m_cnt = 0;
      m_st = (m_s1 == 9) ? 3 : 1;
    end else m_x = nx;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag, int x, int y, int p1, int p2, int s1, int s2, int gs, int go);
    chk({tag, " X"}, int'(x_o), x);
    chk({tag, " Y"}, int'(y_o), y);
    chk({tag, " P1y"}, int'(p1_o), p1);
    chk({tag, " P2y"}, int'(p2_o), p2);
    chk({tag, " score1"}, int'(s1_o), s1);
    chk({tag, " score2"}, int'(s2_o), s2);
    chk({tag, " game_state"}, int'(gs_o), gs);
    chk({tag, " game_over"}, int'(go_o), go);
  endtask

  task automatic check_model(string tag);
    check_all(tag, m_x, m_y, m_p1, m_p2, m_s1, m_s2, m_st, (m_st == 3) ? 1 : 0);
  endtask

  // One clock: drive inputs, take the edge, step the model, sample 1 ns later.
  task automatic do_cycle(bit tick, bit st, logic [3:0] k);
    frame_tick = tick; start = st; key = k;
    @(posedge clk);
    model_cycle(tick, st, k);
    #1;
    frame_tick = 1'b0; start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; key = 4'hF;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    int         n;
    logic [3:0] key;
    int         x, y, p1, p2, s1, s2, gs, go;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, int n, logic [3:0] k, int x, int y, int p1, int p2,
                              int s1, int s2, int gs, int go);
    vec_t v;
    v.rst = r; v.st = s; v.n = n; v.key = k;
    v.x = x; v.y = y; v.p1 = p1; v.p2 = p2; v.s1 = s1; v.s2 = s2; v.gs = gs; v.go = go;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                 rst st  n     key     X    Y    P1   P2  s1 s2 gs go
    vecs.push_back(mk(1, 0,    0, 4'hF,   396, 296, 260, 260, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0,    5, 4'b0111, 396, 296, 260, 260, 0, 0, 0, 0)); // IDLE ignores keys
    vecs.push_back(mk(0, 1,    0, 4'hF,   396, 296, 260, 260, 0, 0, 1, 0)); // start -> SERVE
    vecs.push_back(mk(0, 0,   43, 4'b0111,  396, 296,   2, 260, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,    1, 4'b0111,  396, 296,   0, 260, 0, 0, 1, 0)); // clamp at 0
    vecs.push_back(mk(0, 0,    6, 4'b0111,  396, 296,   0, 260, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,    9, 4'b1011,  396, 296,  54, 260, 0, 0, 1, 0)); // serve tick 59
    vecs.push_back(mk(0, 0,    1, 4'b0011,  396, 296,  54, 260, 0, 0, 2, 0)); // tick 60 -> PLAY, both hold
    vecs.push_back(mk(0, 0,    1, 4'hF,   400, 300,  54, 260, 0, 0, 2, 0)); // first move
    vecs.push_back(mk(0, 0,   73, 4'hF,   692, 592,  54, 260, 0, 0, 2, 0)); // bottom wall
    vecs.push_back(mk(0, 0,   25, 4'hF,   396, 296,  54, 260, 1, 0, 1, 0)); // right miss
    vecs.push_back(mk(1, 0,    0, 4'hF,   396, 296, 260, 260, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,   43, 4'b1110,  396, 296, 260, 518, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   17, 4'b1110,  396, 296, 260, 520, 0, 0, 2, 0)); // clamp at 520
    vecs.push_back(mk(0, 0,   91, 4'hF,   760, 524, 260, 520, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0,    1, 4'hF,   764, 520, 260, 520, 0, 0, 2, 0)); // P2 hit
    vecs.push_back(mk(0, 0,    1, 4'hF,   760, 516, 260, 520, 0, 0, 2, 0)); // travelling left
    vecs.push_back(mk(1, 0,    0, 4'hF,   396, 296, 260, 260, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1430, 4'hF,   788, 496, 260, 260, 8, 0, 2, 0)); // one tick before match point
    vecs.push_back(mk(0, 0,    1, 4'hF,   396, 296, 260, 260, 9, 0, 3, 1)); // OVER
    vecs.push_back(mk(0, 0,    5, 4'b0101, 396, 296, 260, 260, 9, 0, 3, 1)); // frozen
    vecs.push_back(mk(0, 1,    0, 4'hF,   396, 296, 260, 260, 0, 0, 1, 0)); // restart
    vecs.push_back(mk(0, 0,    3, 4'hF,   396, 296, 260, 260, 0, 0, 1, 0));

    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; key = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) do_reset();
      if (v.st) do_cycle(1'b0, 1'b1, 4'hF);
      for (int t = 0; t < v.n; t++) begin
        do_cycle(1'b1, 1'b0, v.key);
        do_cycle(1'b0, 1'b0, v.key);
      end
      check_all($sformatf("row%0d", i), v.x, v.y, v.p1, v.p2, v.s1, v.s2, v.gs, v.go);
      $display("row %0d: X=%0d Y=%0d P1y=%0d P2y=%0d score=%0d:%0d state=%0d over=%0d",
               i, x_o, y_o, p1_o, p2_o, s1_o, s2_o, gs_o, go_o);
    end

    // Randomized play against the model, every cycle compared.
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      bit         tk, st;
      logic [3:0] k;
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 199) == 0);
      k  = 4'($urandom_range(0, 15));
      do_cycle(tk, st, k);
      check_model("rnd");
    end
    $display("random: score=%0d:%0d state=%0d", s1_o, s2_o, gs_o);

    // Asynchronous reset in the middle of play, observed before the next clock edge.
    do_reset();
    do_cycle(1'b0, 1'b1, 4'hF);
    for (int t = 0; t < 70; t++) do_cycle(1'b1, 1'b0, 4'b0111);
    check_model("midplay");
    #2 rst = 1'b1;
    #1 check_all("async_rst", 396, 296, 260, 260, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      do_cycle($urandom_range(0, 1) == 1, c == 3, 4'($urandom_range(0, 15)));
      check_model("post_rst");
    end
    $display("async reset: X=%0d Y=%0d state=%0d", x_o, y_o, gs_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
